// File: rtl/grn_attractor_ctrl.sv
// Sweeps initial states of a bank of GRN boolean-network nodes and finds
// each state's attractor using Floyd cycle detection (tortoise s0, hare s1).
// One result per initial state leaves over a valid/ready port.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   start, first_state,last_state sweep request (range sampled on start)
//   s0_in, s1_in                  node tortoise / hare states
//   reset_nos, start_s0/s1        broadcast load / step strobes to the nodes
//   init_state                    initial state driven to the nodes on load
//   busy, done                    sweep in progress / one-cycle completion pulse
//   res_valid, res_ready          result handshake
//   res_init, res_attractor,
//   res_steps, res_timeout        result payload
module grn_attractor_ctrl #(
  parameter int unsigned NODES     = 8,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned MAX_STEPS = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NODES-1:0] first_state,
  input  logic [NODES-1:0] last_state,
  input  logic [NODES-1:0] s0_in,
  input  logic [NODES-1:0] s1_in,
  output logic             reset_nos,
  output logic             start_s0,
  output logic             start_s1,
  output logic [NODES-1:0] init_state,
  output logic             busy,
  output logic             done,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [NODES-1:0] res_init,
  output logic [NODES-1:0] res_attractor,
  output logic [CNT_W-1:0] res_steps,
  output logic             res_timeout
);

  localparam int unsigned CUR_W = NODES + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_STEP  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_EMIT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]       state_q, state_d;
  // One extra bit so an all-ones last_state can never wrap the sweep.
  logic [CUR_W-1:0] cur_q, cur_d;
  logic [CUR_W-1:0] last_q, last_d;
  logic [CUR_W-1:0] first_ext_c, last_ext_c;
  logic [CNT_W-1:0] k_q, k_d;
  logic [NODES-1:0] res_init_d, res_attr_d;
  logic [CNT_W-1:0] res_steps_d;
  logic             res_tout_d;
  logic             meet_c, at_max_c;

  assign first_ext_c = {1'b0, first_state};
  assign last_ext_c  = {1'b0, last_state};
  assign meet_c      = (s0_in == s1_in);
  assign at_max_c    = (k_q == CNT_W'(MAX_STEPS));

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    last_d      = last_q;
    k_d         = k_q;
    res_init_d  = res_init;
    res_attr_d  = res_attractor;
    res_steps_d = res_steps;
    res_tout_d  = res_timeout;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_d   = first_ext_c;
          last_d  = last_ext_c;
          state_d = (last_ext_c < first_ext_c) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        k_d     = '0;
        state_d = S_STEP;
      end
      S_STEP: begin
        k_d     = k_q + CNT_W'(1);
        state_d = S_CHECK;
      end
      S_CHECK: begin
        // Only even k compares f^(k/2) against f^k; k=1 always looks like a meet.
        state_d = S_STEP;
        if (!k_q[0] && (meet_c || at_max_c)) begin
          res_init_d  = cur_q[NODES-1:0];
          res_attr_d  = s1_in;
          res_steps_d = k_q;
          res_tout_d  = !meet_c;
          state_d     = S_EMIT;
        end
      end
      S_EMIT: begin
        if (res_ready) begin
          if (cur_q == last_q) begin
            state_d = S_DONE;
          end else begin
            cur_d   = cur_q + CUR_W'(1);
            state_d = S_LOAD;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and outputs; outputs are decoded from the next state so
  // they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cur_q         <= '0;
      last_q        <= '0;
      k_q           <= '0;
      reset_nos     <= 1'b0;
      start_s0      <= 1'b0;
      start_s1      <= 1'b0;
      init_state    <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      res_valid     <= 1'b0;
      res_init      <= '0;
      res_attractor <= '0;
      res_steps     <= '0;
      res_timeout   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_q         <= cur_d;
      last_q        <= last_d;
      k_q           <= k_d;
      reset_nos     <= (state_d == S_LOAD);
      start_s0      <= (state_d == S_STEP);
      start_s1      <= (state_d == S_STEP);
      init_state    <= (state_d == S_LOAD) ? cur_d[NODES-1:0] : '0;
      busy          <= (state_d != S_IDLE);
      done          <= (state_d == S_DONE);
      res_valid     <= (state_d == S_EMIT);
      res_init      <= res_init_d;
      res_attractor <= res_attr_d;
      res_steps     <= res_steps_d;
      res_timeout   <= res_tout_d;
    end
  end

endmodule
